// File: rtl/masked_share_decoder_pkg.sv
// Shared types and helpers for the masked share decoder and its refresh stage.
// Default build registers shares unmodified; MASKED_SHARE_DECODER_REFRESH_EN adds a refresh on accept.
package masked_share_decoder_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int NSHARES_DEF = 5;

  // Upper bounds for the generic XOR reduction helper.
  localparam int MAX_WIDTH  = 64;
  localparam int MAX_SHARES = 8;
  localparam int FLAT_BITS  = MAX_WIDTH * MAX_SHARES;
  localparam int FLAT_AW    = $clog2(FLAT_BITS);
  localparam int WORD_AW    = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } decState_e;

  typedef logic [FLAT_BITS-1:0] flatWords_t;

  // XOR of the first count words of the given width packed LSB-first in words.
  function automatic logic [MAX_WIDTH-1:0] xorReduce(input flatWords_t words,
                                                     input int unsigned count,
                                                     input int unsigned width);
    logic [MAX_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_SHARES; i++) begin
      for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
        if (i < count && b < width) begin
          r[WORD_AW'(b)] = r[WORD_AW'(b)] ^ words[FLAT_AW'(i * width + b)];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/masked_share_refresh.sv
// Combinational refresh of NSHARES Boolean shares with NSHARES-1 random words.
// The XOR of all shares is preserved; the last share absorbs the XOR of every random word.
module masked_share_refresh
  import masked_share_decoder_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NSHARES = NSHARES_DEF
) (
  input  logic [NSHARES*WIDTH-1:0]     shares_i,
  input  logic [(NSHARES-1)*WIDTH-1:0] rnd_i,
  output logic [NSHARES*WIDTH-1:0]     shares_o
);

  logic [WIDTH-1:0] rndSum;

  always_comb begin
    rndSum = WIDTH'(xorReduce(flatWords_t'(rnd_i), NSHARES - 1, WIDTH));
    shares_o = '0;
    for (int i = 0; i < NSHARES - 1; i++) begin
      shares_o[i*WIDTH +: WIDTH] = shares_i[i*WIDTH +: WIDTH] ^ rnd_i[i*WIDTH +: WIDTH];
    end
    shares_o[(NSHARES-1)*WIDTH +: WIDTH] = shares_i[(NSHARES-1)*WIDTH +: WIDTH] ^ rndSum;
  end

endmodule

// File: rtl/masked_share_decoder.sv
// Serially recombines an NSHARES-way Boolean-shared word into its plain value, one XOR per cycle.
// Define MASKED_SHARE_DECODER_REFRESH_EN to refresh the shares with the rnd input on accept.
module masked_share_decoder
  import masked_share_decoder_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NSHARES = NSHARES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NSHARES*WIDTH-1:0]     shares_in,
`ifdef MASKED_SHARE_DECODER_REFRESH_EN
  input  logic [(NSHARES-1)*WIDTH-1:0] rnd,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         busy
);

  localparam int IW = $clog2(NSHARES);

  decState_e        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] outData_q, outData_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] share_q [NSHARES];
  logic [WIDTH-1:0] share_d [NSHARES];
  logic [NSHARES*WIDTH-1:0] loadShares;

`ifdef MASKED_SHARE_DECODER_REFRESH_EN
  masked_share_refresh #(
    .WIDTH  (WIDTH),
    .NSHARES(NSHARES)
  ) u_refresh (
    .shares_i(shares_in),
    .rnd_i   (rnd),
    .shares_o(loadShares)
  );
`else
  assign loadShares = shares_in;
`endif

  // Share 0 seeds the accumulator on accept, so it is wiped on the first ACC edge along with share 1.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    outData_d = outData_q;
    idx_d     = idx_q;
    share_d   = share_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < NSHARES; i++) begin
            share_d[i] = loadShares[i*WIDTH +: WIDTH];
          end
          acc_d   = loadShares[WIDTH-1:0];
          idx_d   = IW'(1);
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d          = acc_q ^ share_q[idx_q];
        share_d[0]     = '0;
        share_d[idx_q] = '0;
        idx_d          = idx_q + IW'(1);
        if (idx_q == IW'(NSHARES - 1)) begin
          outData_d = acc_q ^ share_q[idx_q];
          acc_d     = '0;
          idx_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          outData_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      outData_q <= '0;
      idx_q     <= '0;
      share_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      outData_q <= outData_d;
      idx_q     <= idx_d;
      share_q   <= share_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = outData_q;

endmodule
